// File: rtl/uart_fifo_periph_pkg.sv
// Shared definitions for the buffered UART peripheral: register map, STATUS layout,
// serial FSM states and divisor clamp.
package uart_fifo_periph_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_EMPTY = 2;
    localparam int unsigned ST_RX_FULL  = 3;
    localparam int unsigned ST_OVERRUN  = 4;
    localparam int unsigned ST_FRAMERR  = 5;
    localparam int unsigned ST_TXDROP   = 6;
    localparam int unsigned ST_TX_BUSY  = 7;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/uart_fifo_periph_fifo.sv
// Synchronous FIFO with first-word fall-through output; push and pop may coincide
// in any state, including full and empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;
    // When empty, a same-cycle push passes straight through to the popper.
    assign dout      = empty ? din : r_mem[r_rptr];
    assign w_pop_ok  = pop & (~empty | push);
    assign w_push_ok = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART with TX/RX FIFOs, run-time baud divisor, sticky error flags
// and a registered level interrupt.
module uart_fifo_periph
    import uart_fifo_periph_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 27_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic [1:0]  reg_idx,
    input  logic        wstrb,
    input  logic [31:0] wdata,
    input  logic        rstrb,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
    localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);

    logic [15:0] r_div;
    logic [1:0]  r_ctrl;
    logic        r_overrun, r_framerr, r_txdrop;
    logic        r_irq;
    logic [31:0] r_rdata;

    logic             w_wr, w_rd, w_tx_push, w_rx_pop;
    logic [7:0]       w_tx_dout, w_rx_dout;
    logic             w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [TX_CW-1:0] w_tx_count;
    logic [RX_CW-1:0] w_rx_count;
    logic [15:0]      w_status;
    logic             w_unused;

    assign w_wr      = sel & wstrb;
    assign w_rd      = sel & rstrb & ~wstrb;
    assign w_tx_push = w_wr && (reg_idx == REG_DATA);
    assign w_rx_pop  = w_rd && (reg_idx == REG_DATA) && !w_rx_empty;
    assign w_unused  = ^{wdata[31:16], w_tx_count};

    // ---------------- TX engine ----------------
    uart_state_t r_tx_state, w_tx_state_n;
    logic [15:0] r_tx_cnt, w_tx_cnt_n, r_tx_div, w_tx_div_n;
    logic [2:0]  r_tx_bit, w_tx_bit_n;
    logic [7:0]  r_tx_shift, w_tx_shift_n;
    logic        r_tx, w_tx_line, w_tx_pop, w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == r_tx_div - 16'd1);

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_div_n   = r_tx_div;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_pop     = 1'b0;
        w_tx_line    = 1'b1;
        case (r_tx_state)
            UART_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_shift_n = w_tx_dout;
                    w_tx_div_n   = r_div;
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = UART_START;
                end
            end
            UART_START: begin
                w_tx_line = 1'b0;
                if (w_tx_bit_end) begin
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = '0;
                    w_tx_state_n = UART_DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 16'd1;
                end
            end
            UART_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (w_tx_bit_end) begin
                    w_tx_cnt_n   = '0;
                    w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) w_tx_state_n = UART_STOP;
                    else                  w_tx_bit_n   = r_tx_bit + 3'd1;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 16'd1;
                end
            end
            UART_STOP: begin
                w_tx_line = 1'b1;
                if (w_tx_bit_end) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!w_tx_empty) begin
                        w_tx_pop     = 1'b1;
                        w_tx_shift_n = w_tx_dout;
                        w_tx_div_n   = r_div;
                        w_tx_cnt_n   = '0;
                        w_tx_state_n = UART_START;
                    end else begin
                        w_tx_state_n = UART_IDLE;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tx_state <= UART_IDLE;
            r_tx_cnt   <= '0;
            r_tx_div   <= DIV_RESET;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_div   <= w_tx_div_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx       <= w_tx_line;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .resetn(resetn), .push(w_tx_push), .pop(w_tx_pop),
        .din(wdata[7:0]), .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty),
        .count(w_tx_count)
    );

    // ---------------- RX engine ----------------
    uart_state_t r_rx_state, w_rx_state_n;
    logic [15:0] r_rx_cnt, w_rx_cnt_n, r_rx_div, w_rx_div_n, w_rx_half;
    logic [2:0]  r_rx_bit, w_rx_bit_n;
    logic [7:0]  r_rx_shift, w_rx_shift_n;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic        w_rx_push, w_rx_ferr, w_rx_bit_end;

    assign w_rx_bit_end = (r_rx_cnt == r_rx_div - 16'd1);
    // Two synchroniser stages plus edge detect already consume two clocks of the half bit.
    assign w_rx_half    = (r_rx_div >> 1) - 16'd2;

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_div_n   = r_rx_div;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_push    = 1'b0;
        w_rx_ferr    = 1'b0;
        case (r_rx_state)
            UART_IDLE: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_cnt_n   = '0;
                    w_rx_div_n   = r_div;
                    w_rx_state_n = UART_START;
                end
            end
            UART_START: begin
                if (r_rx_cnt == w_rx_half) begin
                    w_rx_cnt_n   = '0;
                    w_rx_bit_n   = '0;
                    w_rx_state_n = r_rx_s2 ? UART_IDLE : UART_DATA;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 16'd1;
                end
            end
            UART_DATA: begin
                if (w_rx_bit_end) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) w_rx_state_n = UART_STOP;
                    else                  w_rx_bit_n   = r_rx_bit + 3'd1;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 16'd1;
                end
            end
            UART_STOP: begin
                if (w_rx_bit_end) begin
                    w_rx_push    = r_rx_s2;
                    w_rx_ferr    = ~r_rx_s2;
                    w_rx_state_n = UART_IDLE;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rx_state <= UART_IDLE;
            r_rx_cnt   <= '0;
            r_rx_div   <= DIV_RESET;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_div   <= w_rx_div_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .resetn(resetn), .push(w_rx_push), .pop(w_rx_pop),
        .din(r_rx_shift), .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty),
        .count(w_rx_count)
    );

    // ---------------- Register file ----------------
    always_comb begin
        w_status              = '0;
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_TX_EMPTY] = w_tx_empty;
        w_status[ST_RX_EMPTY] = w_rx_empty;
        w_status[ST_RX_FULL]  = w_rx_full;
        w_status[ST_OVERRUN]  = r_overrun;
        w_status[ST_FRAMERR]  = r_framerr;
        w_status[ST_TXDROP]   = r_txdrop;
        w_status[ST_TX_BUSY]  = (r_tx_state != UART_IDLE);
        w_status[15:8]        = 8'(w_rx_count);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_div     <= DIV_RESET;
            r_ctrl    <= '0;
            r_overrun <= 1'b0;
            r_framerr <= 1'b0;
            r_txdrop  <= 1'b0;
            r_irq     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_wr && reg_idx == REG_DIV)  r_div  <= clamp_div(wdata[15:0]);
            if (w_wr && reg_idx == REG_CTRL) r_ctrl <= wdata[1:0];
            // A set in the same cycle as a clear wins, so no event is lost.
            r_overrun <= (r_overrun & ~(w_wr && reg_idx == REG_STATUS && wdata[ST_OVERRUN]))
                       | (w_rx_push & w_rx_full & ~w_rx_pop);
            r_framerr <= (r_framerr & ~(w_wr && reg_idx == REG_STATUS && wdata[ST_FRAMERR]))
                       | w_rx_ferr;
            r_txdrop  <= (r_txdrop & ~(w_wr && reg_idx == REG_STATUS && wdata[ST_TXDROP]))
                       | (w_tx_push & w_tx_full & ~w_tx_pop);
            r_irq     <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_empty);
            if (w_rd) begin
                case (reg_idx)
                    REG_DATA:   r_rdata <= w_rx_empty ? '0 : {23'b0, 1'b1, w_rx_dout};
                    REG_STATUS: r_rdata <= {16'b0, w_status};
                    REG_DIV:    r_rdata <= {16'b0, r_div};
                    REG_CTRL:   r_rdata <= {30'b0, r_ctrl};
                endcase
            end
        end
    end

    assign rdata = r_rdata;
    assign tx    = r_tx;
    assign irq   = r_irq;

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Self-checking bench for uart_fifo_periph: bus tasks, serial injector, TX line decoder
// and queue-based expectations.
module tb_uart_fifo_periph;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0, wstrb = 1'b0, rstrb = 1'b0;
    logic [1:0]  reg_idx = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rx, tx, irq;
    logic        rx_drv = 1'b1, loop_en = 1'b0;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    int mon_div = 4;
    logic [7:0]  tx_seen[$];
    int unsigned tx_t[$];

    assign rx = loop_en ? tx : rx_drv;

    uart_fifo_periph #(.CLK_HZ(27_000_000), .BAUD(115_200), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk(clk), .resetn(resetn), .sel(sel), .reg_idx(reg_idx), .wstrb(wstrb),
        .wdata(wdata), .rstrb(rstrb), .rdata(rdata), .rx(rx), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decode frames on tx using the divisor the bench expects.
    initial begin : tx_mon
        logic [7:0] b;
        int unsigned t0;
        forever begin
            @(negedge tx);
            t0 = cyc;
            repeat (mon_div / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (mon_div) @(negedge clk);
                b[i] = tx;
            end
            repeat (mon_div) @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin errors++; $display("FAIL tx_stop: got %b want 1", tx); end
            tx_seen.push_back(b);
            tx_t.push_back(t0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic bus_write(input logic [1:0] idx, input logic [31:0] d);
        @(negedge clk); sel = 1'b1; wstrb = 1'b1; reg_idx = idx; wdata = d;
        @(negedge clk); sel = 1'b0; wstrb = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] idx, output logic [31:0] d);
        @(negedge clk); sel = 1'b1; rstrb = 1'b1; reg_idx = idx;
        @(negedge clk); sel = 1'b0; rstrb = 1'b0;
        d = rdata;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        rx_drv = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (div) @(negedge clk);
        end
        rx_drv = stop;
        repeat (div) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    task automatic wait_rx_count(input int n, output bit ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            bus_read(2'd1, s);
            if (s[15:8] == 8'(n)) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'd234) begin errors++; $display("FAIL rst_div: got %0d want 234", d); end
        bus_read(2'd1, d);
        checks++; if (d !== 32'h06) begin errors++; $display("FAIL rst_status: got %h want 06", d); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", d); end
    endtask

    task automatic test_div_min();
        logic [31:0] d;
        bus_write(2'd2, 32'd1);
        bus_read(2'd2, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL div_clamp1: got %0d want 4", d); end
        bus_write(2'd2, 32'd5);
        bus_read(2'd2, d);
        checks++; if (d !== 32'd5) begin errors++; $display("FAIL div_5: got %0d want 5", d); end
        bus_write(2'd2, 32'd4);
        bus_read(2'd2, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL div_4: got %0d want 4", d); end
    endtask

    task automatic test_loopback();
        logic [31:0] d;
        logic [7:0]  exp[$];
        bit ok;
        tx_seen.delete(); tx_t.delete();
        mon_div = 4;
        loop_en = 1'b1;
        exp.push_back(8'h55); exp.push_back(8'hA3);
        bus_write(2'd0, 32'h55);
        bus_write(2'd0, 32'hA3);
        wait_rx_count(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lb_wait: rx_count never reached 2"); end
        checks++; if (tx_seen.size() != 2) begin errors++; $display("FAIL lb_nframes: got %0d want 2", tx_seen.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= tx_seen.size() || tx_seen[i] !== exp[i]) begin
                errors++; $display("FAIL lb_txbyte%0d: got %h want %h", i, (i < tx_seen.size()) ? tx_seen[i] : 8'hxx, exp[i]);
            end
        end
        checks++;
        if (tx_t.size() < 2 || tx_t[1] - tx_t[0] != 40) begin
            errors++; $display("FAIL lb_spacing: got %0d want 40", (tx_t.size() < 2) ? 0 : tx_t[1] - tx_t[0]);
        end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h155) begin errors++; $display("FAIL lb_rd0: got %h want 155", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h1A3) begin errors++; $display("FAIL lb_rd1: got %h want 1a3", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h000) begin errors++; $display("FAIL lb_rd_empty: got %h want 0", d); end

        exp.delete(); tx_seen.delete(); tx_t.delete();
        for (int i = 0; i < 6; i++) begin
            exp.push_back(8'($urandom_range(0, 255)));
            bus_write(2'd0, {24'h0, exp[i]});
        end
        wait_rx_count(6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lbr_wait: rx_count never reached 6"); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= tx_seen.size() || tx_seen[i] !== exp[i]) begin
                errors++; $display("FAIL lbr_txbyte%0d: got %h want %h", i, (i < tx_seen.size()) ? tx_seen[i] : 8'hxx, exp[i]);
            end
            bus_read(2'd0, d);
            checks++;
            if (d !== {23'h0, 1'b1, exp[i]}) begin errors++; $display("FAIL lbr_rd%0d: got %h want %h", i, d, {23'h0, 1'b1, exp[i]}); end
        end
        loop_en = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic [7:0]  q[$];
        logic        exp_ovr = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            send_rx(8'(i), 1'b1, 4);
            if (q.size() < 16) q.push_back(8'(i));
            else exp_ovr = 1'b1;
        end
        repeat (20) @(negedge clk);
        bus_read(2'd1, d);
        checks++; if (d[15:8] !== 8'(q.size())) begin errors++; $display("FAIL ovr_count: got %0d want %0d", d[15:8], q.size()); end
        checks++; if (d[4] !== exp_ovr) begin errors++; $display("FAIL ovr_flag: got %b want %b", d[4], exp_ovr); end
        checks++; if (d[3] !== 1'b1) begin errors++; $display("FAIL ovr_rxfull: got %b want 1", d[3]); end
        while (q.size() > 0) begin
            logic [7:0] e;
            e = q.pop_front();
            bus_read(2'd0, d);
            checks++; if (d !== {23'h0, 1'b1, e}) begin errors++; $display("FAIL ovr_rd: got %h want %h", d, {23'h0, 1'b1, e}); end
        end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovr_rd_empty: got %h want 0", d); end
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, d);
        checks++; if (d[4] !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", d[4]); end
    endtask

    task automatic test_framing();
        logic [31:0] d;
        @(negedge clk); rx_drv = 1'b0;
        @(negedge clk); rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        bus_read(2'd1, d);
        checks++; if (d[2] !== 1'b1 || d[5] !== 1'b0) begin errors++; $display("FAIL glitch: got rx_empty=%b framerr=%b want 1 0", d[2], d[5]); end
        send_rx(8'h3C, 1'b0, 4);
        repeat (10) @(negedge clk);
        bus_read(2'd1, d);
        checks++; if (d[5] !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", d[5]); end
        checks++; if (d[2] !== 1'b1) begin errors++; $display("FAIL ferr_rxempty: got %b want 1", d[2]); end
        bus_write(2'd1, 32'h20);
        bus_read(2'd1, d);
        checks++; if (d[5] !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", d[5]); end
    endtask

    task automatic test_tx_full();
        logic [31:0] d;
        logic [7:0]  exp[$];
        bit          sp_ok;
        bus_write(2'd2, 32'd40);
        mon_div = 40;
        tx_seen.delete(); tx_t.delete();
        for (int i = 0; i < 18; i++) begin
            exp.push_back(8'($urandom_range(0, 255)));
            bus_write(2'd0, {24'h0, exp[i]});
        end
        // First byte is in flight, 16 queued, 18th dropped; hold a write across the next pop.
        @(negedge clk); sel = 1'b1; wstrb = 1'b1; reg_idx = 2'd0; wdata = 32'hE7;
        repeat (450) @(negedge clk);
        sel = 1'b0; wstrb = 1'b0;
        bus_read(2'd1, d);
        checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL txf_full: got %b want 1", d[0]); end
        checks++; if (d[6] !== 1'b1) begin errors++; $display("FAIL txf_drop: got %b want 1", d[6]); end
        checks++; if (d[7] !== 1'b1) begin errors++; $display("FAIL txf_busy: got %b want 1", d[7]); end
        for (int i = 0; i < 20000 && tx_seen.size() < 18; i++) @(negedge clk);
        repeat (900) @(negedge clk);
        checks++; if (tx_seen.size() != 18) begin errors++; $display("FAIL txf_nframes: got %0d want 18", tx_seen.size()); end
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (i >= tx_seen.size() || tx_seen[i] !== exp[i]) begin
                errors++; $display("FAIL txf_byte%0d: got %h want %h", i, (i < tx_seen.size()) ? tx_seen[i] : 8'hxx, exp[i]);
            end
        end
        checks++;
        if (tx_seen.size() < 18 || tx_seen[17] !== 8'hE7) begin errors++; $display("FAIL txf_pushpop_full: 18th frame got %h want e7", (tx_seen.size() >= 18) ? tx_seen[17] : 8'hxx); end
        sp_ok = (tx_t.size() >= 18);
        for (int i = 0; i + 1 < tx_t.size(); i++) if (tx_t[i+1] - tx_t[i] != 400) sp_ok = 1'b0;
        checks++; if (!sp_ok) begin errors++; $display("FAIL txf_gapless: frame spacing not 400 clocks"); end
        bus_read(2'd1, d);
        checks++; if (d[1] !== 1'b1 || d[7] !== 1'b0) begin errors++; $display("FAIL txf_done: got tx_empty=%b busy=%b want 1 0", d[1], d[7]); end
        bus_write(2'd1, 32'h40);
        bus_read(2'd1, d);
        checks++; if (d[6] !== 1'b0) begin errors++; $display("FAIL txf_drop_clear: got %b want 0", d[6]); end
    endtask

    task automatic test_irq_reset();
        logic [31:0] d;
        bit rose;
        bus_write(2'd2, 32'd4);
        mon_div = 4;
        bus_write(2'd3, 32'hFFFF_FFFD);
        bus_read(2'd3, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL ctrl_rd: got %h want 1", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
        send_rx(8'h7E, 1'b1, 4);
        rose = 1'b0;
        for (int i = 0; i < 20 && !rose; i++) begin @(negedge clk); rose = (irq === 1'b1); end
        checks++; if (!rose) begin errors++; $display("FAIL irq_rx: got 0 want 1"); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h17E) begin errors++; $display("FAIL irq_rd: got %h want 17e", d); end
        repeat (2) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", irq); end
        bus_write(2'd3, 32'h2);
        repeat (2) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_txempty: got %b want 1", irq); end
        bus_write(2'd3, 32'h1);
        send_rx(8'h11, 1'b1, 4);
        repeat (20) @(negedge clk);

        bus_write(2'd2, 32'd40);
        mon_div = 40;
        for (int i = 0; i < 3; i++) bus_write(2'd0, 32'($urandom_range(0, 255)));
        repeat (150) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_rst_irq: got %b want 1", irq); end
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq: got %b want 0", irq); end
        @(negedge clk); resetn = 1'b1;
        bus_read(2'd1, d);
        checks++; if (d !== 32'h06) begin errors++; $display("FAIL rst_mid_status: got %h want 06", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", d); end
        repeat (500) @(negedge clk);
        tx_seen.delete();
        repeat (500) @(negedge clk);
        checks++; if (tx_seen.size() != 0 || tx !== 1'b1) begin errors++; $display("FAIL rst_mid_quiet: got %0d frames tx=%b want 0 frames tx=1", tx_seen.size(), tx); end
    endtask

    initial begin
        test_reset();
        test_div_min();
        test_loopback();
        test_overrun();
        test_framing();
        test_tx_full();
        test_irq_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
